// File: rtl/sysid_probe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sysid_probe_pkg
// Brief    : Shared state encoding and constants for the system-ID probe.
// Revision : 1.0 - initial release
// ============================================================================
package sysid_probe_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_ID = 3'd1,
        LAT_ID = 3'd2,
        REQ_TS = 3'd3,
        LAT_TS = 3'd4,
        DONE   = 3'd5
    } sysid_probe_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;
    localparam int   SYSID_LAT_MAX = 3;

endpackage
`default_nettype wire

// File: rtl/sysid_probe.sv
`default_nettype none
// ============================================================================
// Module   : sysid_probe
// Brief    : Avalon-MM read master that fetches the system-ID and timestamp
//            words and flags whether they match the build-time values.
// Revision : 1.0 - initial release
// ============================================================================
module sysid_probe
    import sysid_probe_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        valid_pulse,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    generate
        if (READ_LATENCY < 0 || READ_LATENCY > SYSID_LAT_MAX ||
            TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
            $fatal(1, "sysid_probe: READ_LATENCY or TIMEOUT_CYCLES out of range");
        end
    endgenerate

    localparam bit          c_has_lat    = (READ_LATENCY > 0);
    localparam logic [1:0]  c_lat_last   = c_has_lat ? 2'(READ_LATENCY - 1) : 2'd0;
    localparam logic [15:0] c_stall_last = 16'(TIMEOUT_CYCLES - 1);

    sysid_probe_state_t r_state;
    sysid_probe_state_t w_next;
    logic               r_auto;
    logic [1:0]         r_lat;
    logic [15:0]        r_stall;

    logic w_launch;
    logic w_cap_id;
    logic w_cap_ts;
    logic w_abort;
    logic w_stall_hit;
    logic w_lat_hit;

    // Bus strobes come straight from the state register so they hold steady under stalls.
    assign avm_read    = (r_state == REQ_ID) || (r_state == REQ_TS);
    assign avm_address = (r_state == REQ_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

    always_comb begin
        w_next      = r_state;
        w_launch    = 1'b0;
        w_cap_id    = 1'b0;
        w_cap_ts    = 1'b0;
        w_abort     = 1'b0;
        w_stall_hit = avm_waitrequest && (r_stall == c_stall_last);
        w_lat_hit   = (r_lat == c_lat_last);
        case (r_state)
            IDLE: begin
                if (r_auto || start) begin
                    w_next   = REQ_ID;
                    w_launch = 1'b1;
                end
            end
            REQ_ID: begin
                if (!avm_waitrequest) begin
                    if (c_has_lat) begin
                        w_next = LAT_ID;
                    end else begin
                        w_next   = REQ_TS;
                        w_cap_id = 1'b1;
                    end
                end else if (w_stall_hit) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            LAT_ID: begin
                if (w_lat_hit) begin
                    w_next   = REQ_TS;
                    w_cap_id = 1'b1;
                end
            end
            REQ_TS: begin
                if (!avm_waitrequest) begin
                    if (c_has_lat) begin
                        w_next = LAT_TS;
                    end else begin
                        w_next   = DONE;
                        w_cap_ts = 1'b1;
                    end
                end else if (w_stall_hit) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            LAT_TS: begin
                if (w_lat_hit) begin
                    w_next   = DONE;
                    w_cap_ts = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    w_next   = REQ_ID;
                    w_launch = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_auto      <= AUTO_START;
            r_lat       <= 2'd0;
            r_stall     <= 16'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            valid_pulse <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
        end else begin
            r_state <= w_next;
            r_auto  <= 1'b0;
            // Stall count is zero outside REQ cycles, so every REQ entry starts fresh.
            r_stall <= (avm_read && avm_waitrequest) ? r_stall + 16'd1 : 16'd0;
            r_lat   <= ((r_state == LAT_ID) || (r_state == LAT_TS)) ? r_lat + 2'd1 : 2'd0;

            busy        <= (w_next == REQ_ID) || (w_next == LAT_ID) ||
                           (w_next == REQ_TS) || (w_next == LAT_TS);
            done        <= (w_next == DONE);
            valid_pulse <= (w_next == DONE) && (r_state != DONE);

            if (w_launch) begin
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if (w_cap_id) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (w_cap_ts) begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TS);
            end
            if (w_abort) begin
                timeout <= 1'b1;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sysid_probe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysid_probe
// Brief    : Self-checking bench for sysid_probe, two instances (latency 0 and 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysid_probe;

    localparam logic [31:0] EXP_ID0 = 32'h0000_0000;
    localparam logic [31:0] EXP_TS0 = 32'h525E_9045;
    localparam logic [31:0] EXP_ID1 = 32'hC0DE_0001;
    localparam logic [31:0] EXP_TS1 = 32'h6000_0000;
    localparam int          LAT0    = 0;
    localparam int          LAT1    = 2;
    localparam int          TMO     = 4;

    typedef struct {
        int   done_at;
        int   vp_count;
        int   vp_at;
        int   busy_bad;
        int   unstable;
        logic rd_at_done;
    } obs_t;

    typedef struct {
        int          done_at;
        logic        to;
        logic        idok;
        logic        tsok;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          nreads;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst[2], start[2], waitreq[2];
    logic [31:0] rdata[2];
    logic        rd[2], adr[2], busy[2], done[2], vp[2], idok[2], tsok[2], tmo[2];
    logic [31:0] idv[2], tsv[2];

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  acc_h[2], adr_h[2];
    int          stall_id[2], stall_ts[2], reads[2];
    logic [31:0] w0[2], w1[2], m_idv[2], m_tsv[2];

    sysid_probe #(
        .EXPECTED_ID(EXP_ID0), .EXPECTED_TS(EXP_TS0), .READ_LATENCY(LAT0),
        .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
    ) dut0 (
        .clock(clk), .reset(rst[0]), .start(start[0]),
        .avm_address(adr[0]), .avm_read(rd[0]), .avm_waitrequest(waitreq[0]),
        .avm_readdata(rdata[0]), .busy(busy[0]), .done(done[0]),
        .valid_pulse(vp[0]), .id_ok(idok[0]), .ts_ok(tsok[0]), .timeout(tmo[0]),
        .id_value(idv[0]), .ts_value(tsv[0])
    );

    sysid_probe #(
        .EXPECTED_ID(EXP_ID1), .EXPECTED_TS(EXP_TS1), .READ_LATENCY(LAT1),
        .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
    ) dut1 (
        .clock(clk), .reset(rst[1]), .start(start[1]),
        .avm_address(adr[1]), .avm_read(rd[1]), .avm_waitrequest(waitreq[1]),
        .avm_readdata(rdata[1]), .busy(busy[1]), .done(done[1]),
        .valid_pulse(vp[1]), .id_ok(idok[1]), .ts_ok(tsok[1]), .timeout(tmo[1]),
        .id_value(idv[1]), .ts_value(tsv[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    // Slave model: first stall_x cycles of each read are stalled; data appears
    // exactly L cycles after acceptance, random garbage otherwise.
    task automatic step(input int d);
        int   L;
        logic acc;
        L = lat_of(d);
        @(negedge clk);
        if (rd[d] === 1'b1 && adr[d] === 1'b0 && stall_id[d] > 0) begin
            waitreq[d]  = 1'b1;
            stall_id[d] = stall_id[d] - 1;
        end else if (rd[d] === 1'b1 && adr[d] === 1'b1 && stall_ts[d] > 0) begin
            waitreq[d]  = 1'b1;
            stall_ts[d] = stall_ts[d] - 1;
        end else begin
            waitreq[d] = 1'b0;
        end
        acc = (rd[d] === 1'b1) && !waitreq[d];
        if (acc) reads[d] = reads[d] + 1;
        acc_h[d] = {acc_h[d][2:0], acc};
        adr_h[d] = {adr_h[d][2:0], adr[d]};
        rdata[d] = acc_h[d][L] ? (adr_h[d][L] ? w1[d] : w0[d]) : 32'($urandom);
    endtask

    // Expected outcome of one probe from the stall budgets and word contents.
    task automatic model_probe(input int d, input int s_id, input int s_ts, output exp_t e);
        int L;
        L = lat_of(d);
        if (s_id >= TMO) begin
            e.done_at = TMO + 1;
            e.to      = 1'b1;
            e.nreads  = 0;
        end else if (s_ts >= TMO) begin
            e.done_at = s_id + 1 + L + TMO + 1;
            e.to      = 1'b1;
            e.nreads  = 1;
            m_idv[d]  = w0[d];
        end else begin
            e.done_at = s_id + s_ts + 2 * (1 + L) + 1;
            e.to      = 1'b0;
            e.nreads  = 2;
            m_idv[d]  = w0[d];
            m_tsv[d]  = w1[d];
        end
        e.idok = !e.to && (w0[d] == ((d == 0) ? EXP_ID0 : EXP_ID1));
        e.tsok = !e.to && (w1[d] == ((d == 0) ? EXP_TS0 : EXP_TS1));
        e.idv  = m_idv[d];
        e.tsv  = m_tsv[d];
    endtask

    // Observes a probe whose launch edge has just been set up; cycle k follows launch edge + k-1.
    task automatic run_probe(input int d, input int start_at, output obs_t o);
        logic p_rd, p_adr, p_wait;
        o.done_at = -1; o.vp_count = 0; o.vp_at = -1;
        o.busy_bad = 0; o.unstable = 0; o.rd_at_done = 1'b1;
        p_rd = 1'b0; p_adr = 1'b0; p_wait = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step(d);
            start[d] = (k == start_at);
            if (done[d] === 1'b1 && o.done_at < 0) begin
                o.done_at    = k;
                o.rd_at_done = rd[d];
            end
            if (vp[d] === 1'b1) begin
                o.vp_count++;
                o.vp_at = k;
            end
            if (busy[d] !== (o.done_at < 0)) o.busy_bad++;
            if (p_wait && p_rd && done[d] !== 1'b1 && (rd[d] !== 1'b1 || adr[d] !== p_adr))
                o.unstable++;
            p_rd = rd[d]; p_adr = adr[d]; p_wait = waitreq[d];
            if (o.done_at > 0 && k >= o.done_at + 2) break;
        end
    endtask

    task automatic launch(input int d, input int s_id, input int s_ts);
        stall_id[d] = s_id;
        stall_ts[d] = s_ts;
        reads[d]    = 0;
        step(d);
        start[d] = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], done[d], vp[d], idok[d], tsok[d], tmo[d], rd[d], adr[d], idv[d], tsv[d]} !== 72'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got busy=%b done=%b vp=%b idok=%b tsok=%b tmo=%b rd=%b adr=%b id=%h ts=%h, expected all 0",
                         d, busy[d], done[d], vp[d], idok[d], tsok[d], tmo[d], rd[d], adr[d], idv[d], tsv[d]);
            end
        end
    endtask

    task automatic test_auto_start();
        exp_t e; obs_t o;
        w0[0] = 32'h0; w1[0] = 32'h525E_9045;
        stall_id[0] = 0; stall_ts[0] = 0; reads[0] = 0;
        model_probe(0, 0, 0, e);
        step(0);
        rst[0] = 1'b0;
        run_probe(0, 0, o);
        checks++; if (o.done_at !== 3) begin errors++; $display("FAIL auto_done_at: got %0d expected 3", o.done_at); end
        checks++; if (idok[0] !== 1'b1 || tsok[0] !== 1'b1) begin errors++; $display("FAIL auto_ok: got id_ok=%b ts_ok=%b expected 1 1", idok[0], tsok[0]); end
        checks++; if (o.vp_count !== 1 || o.vp_at !== 3) begin errors++; $display("FAIL auto_valid_pulse: got count=%0d at=%0d expected 1 at 3", o.vp_count, o.vp_at); end
        checks++; if (o.busy_bad !== 0) begin errors++; $display("FAIL auto_busy: got %0d bad cycles expected 0", o.busy_bad); end
        checks++; if (tsv[0] !== e.tsv || idv[0] !== e.idv) begin errors++; $display("FAIL auto_values: got id=%h ts=%h expected %h %h", idv[0], tsv[0], e.idv, e.tsv); end
    endtask

    task automatic test_ts_mismatch();
        exp_t e; obs_t o;
        w1[0] = 32'h525E_9046;
        model_probe(0, 0, 0, e);
        launch(0, 0, 0);
        run_probe(0, 0, o);
        checks++; if (o.done_at !== 3) begin errors++; $display("FAIL mism_done_at: got %0d expected 3", o.done_at); end
        checks++; if (idok[0] !== 1'b1 || tsok[0] !== 1'b0 || tmo[0] !== 1'b0) begin errors++; $display("FAIL mism_flags: got id_ok=%b ts_ok=%b tmo=%b expected 1 0 0", idok[0], tsok[0], tmo[0]); end
        checks++; if (tsv[0] !== 32'h525E_9046) begin errors++; $display("FAIL mism_ts_value: got %h expected 525e9046", tsv[0]); end
    endtask

    task automatic test_latency_stalls();
        exp_t e; obs_t o;
        w0[1] = EXP_ID1; w1[1] = EXP_TS1;
        stall_id[1] = 3; stall_ts[1] = 3; reads[1] = 0;
        model_probe(1, 3, 3, e);
        step(1);
        rst[1] = 1'b0;
        run_probe(1, 0, o);
        checks++; if (o.done_at !== 13) begin errors++; $display("FAIL lat_auto_done_at: got %0d expected 13", o.done_at); end
        checks++; if (o.unstable !== 0) begin errors++; $display("FAIL lat_stable: got %0d unstable cycles expected 0", o.unstable); end
        checks++; if (idok[1] !== 1'b1 || tsok[1] !== 1'b1 || reads[1] !== 2) begin errors++; $display("FAIL lat_result: got id_ok=%b ts_ok=%b reads=%0d expected 1 1 2", idok[1], tsok[1], reads[1]); end
        w1[1] = EXP_TS1 ^ 32'h1;
        model_probe(1, 3, 3, e);
        launch(1, 3, 3);
        run_probe(1, 0, o);
        checks++; if (o.done_at !== 13 || o.busy_bad !== 0) begin errors++; $display("FAIL lat_start_timing: got done_at=%0d busy_bad=%0d expected 13 0", o.done_at, o.busy_bad); end
        checks++; if (tsok[1] !== 1'b0 || tsv[1] !== e.tsv) begin errors++; $display("FAIL lat_start_ts: got ts_ok=%b ts=%h expected 0 %h", tsok[1], tsv[1], e.tsv); end
    endtask

    task automatic test_timeout();
        exp_t e; obs_t o;
        model_probe(0, 1000, 0, e);
        launch(0, 1000, 0);
        run_probe(0, 0, o);
        checks++; if (o.done_at !== 5) begin errors++; $display("FAIL tmo_done_at: got %0d expected 5", o.done_at); end
        checks++; if (tmo[0] !== 1'b1 || idok[0] !== 1'b0 || tsok[0] !== 1'b0) begin errors++; $display("FAIL tmo_flags: got tmo=%b id_ok=%b ts_ok=%b expected 1 0 0", tmo[0], idok[0], tsok[0]); end
        checks++; if (o.rd_at_done !== 1'b0 || reads[0] !== 0) begin errors++; $display("FAIL tmo_read: got read=%b reads=%0d expected 0 0", o.rd_at_done, reads[0]); end
        w1[0] = EXP_TS0;
        model_probe(0, 0, 0, e);
        launch(0, 0, 0);
        run_probe(0, 0, o);
        checks++; if (tmo[0] !== 1'b0 || idok[0] !== 1'b1 || tsok[0] !== 1'b1) begin errors++; $display("FAIL tmo_recover: got tmo=%b id_ok=%b ts_ok=%b expected 0 1 1", tmo[0], idok[0], tsok[0]); end
        w0[1] = 32'hAAAA_5555;
        model_probe(1, 1, 6, e);
        launch(1, 1, 6);
        run_probe(1, 0, o);
        checks++; if (o.done_at !== 9 || tmo[1] !== 1'b1) begin errors++; $display("FAIL tmo_ts_word: got done_at=%0d tmo=%b expected 9 1", o.done_at, tmo[1]); end
        checks++; if (idv[1] !== 32'hAAAA_5555 || idok[1] !== 1'b0 || reads[1] !== 1) begin errors++; $display("FAIL tmo_ts_capture: got id=%h id_ok=%b reads=%0d expected aaaa5555 0 1", idv[1], idok[1], reads[1]); end
    endtask

    task automatic test_ignored_start();
        exp_t e; obs_t o;
        model_probe(0, 0, 0, e);
        launch(0, 0, 0);
        run_probe(0, 2, o);
        checks++; if (o.done_at !== 3 || reads[0] !== 2) begin errors++; $display("FAIL ign_start: got done_at=%0d reads=%0d expected 3 2", o.done_at, reads[0]); end
        checks++; if (o.vp_count !== 1 || done[0] !== 1'b1 || busy[0] !== 1'b0) begin errors++; $display("FAIL ign_hold: got vp=%0d done=%b busy=%b expected 1 1 0", o.vp_count, done[0], busy[0]); end
    endtask

    task automatic test_reset_mid();
        exp_t e; obs_t o;
        w0[1] = EXP_ID1; w1[1] = EXP_TS1;
        launch(1, 0, 0);
        step(1);
        start[1] = 1'b0;
        step(1);
        checks++; if (busy[1] !== 1'b1 || rd[1] !== 1'b0) begin errors++; $display("FAIL mid_in_lat: got busy=%b read=%b expected 1 0", busy[1], rd[1]); end
        rst[1] = 1'b1;
        step(1);
        checks++;
        if ({busy[1], done[1], vp[1], idok[1], tsok[1], tmo[1], rd[1], adr[1], idv[1], tsv[1]} !== 72'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b rd=%b id=%h ts=%h expected all 0", busy[1], done[1], rd[1], idv[1], tsv[1]);
        end
        m_idv[1] = 32'd0; m_tsv[1] = 32'd0;
        reads[1] = 0;
        rst[1] = 1'b0;
        model_probe(1, 0, 0, e);
        run_probe(1, 0, o);
        checks++; if (o.done_at !== 7 || idok[1] !== 1'b1 || tsok[1] !== 1'b1) begin errors++; $display("FAIL mid_restart: got done_at=%0d id_ok=%b ts_ok=%b expected 7 1 1", o.done_at, idok[1], tsok[1]); end
    endtask

    task automatic test_random();
        exp_t e; obs_t o;
        int d, s_id, s_ts, st;
        for (int it = 0; it < 30; it++) begin
            d    = $urandom_range(0, 1);
            w0[d] = $urandom_range(0, 1) ? ((d == 0) ? EXP_ID0 : EXP_ID1) : 32'($urandom);
            w1[d] = $urandom_range(0, 1) ? ((d == 0) ? EXP_TS0 : EXP_TS1) : 32'($urandom);
            s_id = ($urandom_range(0, 5) == 0) ? 5 : $urandom_range(0, 3);
            s_ts = ($urandom_range(0, 5) == 0) ? 5 : $urandom_range(0, 3);
            model_probe(d, s_id, s_ts, e);
            st = $urandom_range(0, 1) ? $urandom_range(1, e.done_at - 1) : 0;
            launch(d, s_id, s_ts);
            run_probe(d, st, o);
            checks++;
            if (o.done_at !== e.done_at || tmo[d] !== e.to || idok[d] !== e.idok || tsok[d] !== e.tsok) begin
                errors++;
                $display("FAIL rand_flags it%0d dut%0d: got done_at=%0d tmo=%b id_ok=%b ts_ok=%b expected %0d %b %b %b",
                         it, d, o.done_at, tmo[d], idok[d], tsok[d], e.done_at, e.to, e.idok, e.tsok);
            end
            checks++;
            if (idv[d] !== e.idv || tsv[d] !== e.tsv || reads[d] !== e.nreads) begin
                errors++;
                $display("FAIL rand_values it%0d dut%0d: got id=%h ts=%h reads=%0d expected %h %h %0d",
                         it, d, idv[d], tsv[d], reads[d], e.idv, e.tsv, e.nreads);
            end
            checks++;
            if (o.vp_count !== 1 || o.busy_bad !== 0 || o.unstable !== 0) begin
                errors++;
                $display("FAIL rand_protocol it%0d dut%0d: got vp=%0d busy_bad=%0d unstable=%0d expected 1 0 0",
                         it, d, o.vp_count, o.busy_bad, o.unstable);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; waitreq[d] = 1'b0; rdata[d] = 32'd0;
            acc_h[d] = 4'd0; adr_h[d] = 4'd0;
            stall_id[d] = 0; stall_ts[d] = 0; reads[d] = 0;
            w0[d] = 32'd0; w1[d] = 32'd0; m_idv[d] = 32'd0; m_tsv[d] = 32'd0;
        end
        test_reset();
        test_auto_start();
        test_ts_mismatch();
        test_latency_stalls();
        test_timeout();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
